// File: rtl/sar_pwm_controller.sv
// sar_pwm_controller: successive-approximation sequencer that drives a PWM DAC with the
// current trial code and resolves one bit per settle window from the external comparator.
module sar_pwm_controller #(
  parameter int N_BITS = 8,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stb,
  input  logic              i_start,
  input  logic              i_cmp,
  output logic              o_pwm,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_BITS-1:0] o_data
);
  localparam int BW = $clog2(N_BITS);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, DECIDE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [N_BITS-1:0] cnt_q, trial_q, trial_d, data_q, data_d, mask, result;
  logic [BW-1:0] idx_q, idx_d;
  logic [7:0] settle_q, settle_d;
  logic cmp_m_q, cmp_s_q, busy_q, busy_d, done_q, done_d, pwm_q, wrap;
  assign wrap = i_stb && (&cnt_q);
  assign mask = N_BITS'(1) << idx_q;
  assign result = (trial_q & ~mask) | (cmp_s_q ? mask : '0);
  always_comb begin
    state_d = state_q;
    trial_d = trial_q;
    idx_d = idx_q;
    settle_d = settle_q;
    busy_d = busy_q;
    done_d = 1'b0;
    data_d = data_q;
    case (state_q)
      IDLE: if (i_start) begin
        trial_d = N_BITS'(1) << (N_BITS - 1);
        idx_d = BW'(N_BITS - 1);
        settle_d = '0;
        busy_d = 1'b1;
        state_d = SETTLE;
      end
      // A partial first period still counts, so only wraps are tallied here.
      SETTLE: if (wrap) begin
        settle_d = settle_q + 8'd1;
        state_d = (settle_d == 8'(SETTLE_PERIODS)) ? DECIDE : SETTLE;
      end
      DECIDE: if (idx_q != '0) begin
        trial_d = result | (mask >> 1);
        idx_d = idx_q - BW'(1);
        settle_d = '0;
        state_d = SETTLE;
      end else begin
        data_d = result;
        done_d = 1'b1;
        busy_d = 1'b0;
        trial_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      trial_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      settle_q <= '0;
      cmp_m_q <= 1'b0;
      cmp_s_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + N_BITS'(i_stb);
      trial_q <= trial_d;
      data_q <= data_d;
      idx_q <= idx_d;
      settle_q <= settle_d;
      cmp_m_q <= i_cmp;
      cmp_s_q <= cmp_m_q;
      busy_q <= busy_d;
      done_q <= done_d;
      pwm_q <= busy_q && (cnt_q < trial_q);
    end
  end
  assign o_pwm = pwm_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_data = data_q;
endmodule

// File: tb/tb_sar_pwm_controller.sv
// tb_sar_pwm_controller: randomized-timing bench with a behavioural conversion model
// checked against the DUT every clock, plus literal expectations for the planned scenarios.
module tb_sar_pwm_controller;
  localparam int N = 8;
  localparam int SP = 4;
  logic clk, rst, stb, start, cmp;
  logic pwm, busy, done;
  logic [N-1:0] data;
  int n_chk = 0, n_fail = 0, n_done = 0;
  bit chk_en = 0;
  int mode;
  bit [N-1:0] target;

  sar_pwm_controller #(.N_BITS(N), .SETTLE_PERIODS(SP)) dut (
    .i_clk(clk), .i_rst(rst), .i_stb(stb), .i_start(start), .i_cmp(cmp),
    .o_pwm(pwm), .o_busy(busy), .o_done(done), .o_data(data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: conversion described by wraps since start; bit b is decided on the clock
  // after wrap number SP*(N-b), using the comparator seen two edges earlier.
  int m_cnt, m_wraps, m_bp;
  bit m_busy, m_done, m_pwm, m_pend, m_cm, m_cs, m_wrap;
  bit [N-1:0] m_trial, m_data, m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_wraps = 0; m_busy = 0; m_done = 0; m_pwm = 0; m_pend = 0;
      m_cm = 0; m_cs = 0; m_trial = 0; m_data = 0;
    end else begin
      m_wrap = stb && m_cnt == (1 << N) - 1;
      m_pwm = m_busy && (m_cnt < int'(m_trial));
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_trial = 1 << (N - 1); m_wraps = 0; m_pend = 0;
        end
      end else if (m_pend) begin
        m_bp = N - m_wraps / SP;
        m_res = m_trial;
        m_res[m_bp] = m_cs;
        if (m_bp > 0) m_trial = m_res | (N'(1) << (m_bp - 1));
        else begin
          m_data = m_res; m_done = 1; m_busy = 0; m_trial = 0;
        end
        m_pend = 0;
      end else if (m_wrap) begin
        m_wraps++;
        m_pend = (m_wraps % SP == 0);
      end
      if (stb) m_cnt = (m_cnt + 1) % (1 << N);
      m_cs = m_cm;
      m_cm = cmp;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("pwm", pwm, m_pwm);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("data", data, m_data);
    if (done === 1'b1) n_done++;
  end

  // Strobe every second clock; comparator follows the modelled analog input (target + 1/2 LSB).
  initial begin
    stb = 0; cmp = 0;
    forever begin
      @(negedge clk);
      stb = !stb;
      cmp = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (target >= m_trial);
    end
  end

  task automatic start_pulse;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic gap;
    repeat ($urandom_range(1, 40)) @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int n;
    for (n = 0; n < 20000 && done !== 1'b1; n++) @(negedge clk);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_low_with_done"}, busy, 0);
  endtask

  task automatic wait_wraps(input int w);
    int n;
    for (n = 0; n < 20000 && m_wraps != w; n++) @(negedge clk);
    chk("reach_wraps", m_wraps, w);
  endtask

  task automatic duty(input string nm, input int exp_slots);
    int hi;
    hi = 0;
    for (int i = 0; i < 2 * (1 << N); i++) begin
      @(negedge clk);
      hi += int'(pwm);
    end
    chk(nm, hi / 2, exp_slots);
  endtask

  initial begin
    int d0, n;
    rst = 0; start = 0; mode = 2; target = 0;
    #2 rst = 1;
    #1;
    chk("rst_async_pwm", pwm, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_data", data, 0);
    chk_en = 1;
    repeat (5) @(negedge clk);
    rst = 0;
    // Conversion of 0xA5 with duty measurements in the first two bit windows.
    mode = 2; target = 8'hA5;
    gap();
    start_pulse();
    repeat (600) @(negedge clk);
    duty("duty_trial_80", 128);
    for (n = 0; n < 4000 && m_trial != 8'hC0; n++) @(negedge clk);
    chk("reach_trial_C0", m_trial, 8'hC0);
    repeat (100) @(negedge clk);
    duty("duty_trial_C0", 192);
    wait_done("conv_A5");
    chk("data_A5", data, 8'hA5);
    chk("model_A5", m_data, 8'hA5);
    // Start request during bit 3 must be ignored.
    mode = 2; target = 8'h3C;
    gap();
    d0 = n_done;
    start_pulse();
    wait_wraps(17);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("conv_3C");
    chk("data_3C", data, 8'h3C);
    repeat (20) @(negedge clk);
    chk("one_done_3C", n_done - d0, 1);
    // Reset during bit 5 of a random-target conversion.
    mode = 2; target = 8'($urandom_range(0, 255));
    gap();
    d0 = n_done;
    start_pulse();
    wait_wraps(9);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pwm", pwm, 0);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_model_data", m_data, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_mid_no_done", n_done - d0, 0);
    // Comparator tied high, then tied low with start right after done.
    mode = 1;
    gap();
    start_pulse();
    wait_done("conv_ones");
    chk("data_FF", data, 8'hFF);
    mode = 0;
    start_pulse();
    wait_done("conv_zeros");
    chk("data_00", data, 8'h00);
    chk("model_00", m_data, 8'h00);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
